doorlock_ctrl_param: RTL and testbench

Parametrised successor to the fixed 2-bit doorlock: password entry controller with configurable length, a programmable stored password, a failed-attempt lockout and tick-based auto-relock/timeouts.
Sits between the key-pad front end and the 7-segment decoder.
Replaces the separate divider + state machine + compare path with one synchronous block.
Emits a display code for a downstream seg7 decoder.

---
 rtl/doorlock_ctrl_param_if.sv | 30 +++
 rtl/doorlock_ctrl_param.sv | 231 +++++++++++++++++++++++
 tb/tb_doorlock_ctrl_param.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/doorlock_ctrl_param_if.sv
// Key-pad / lock-status bundle between the front end and doorlock_ctrl_param.
// slave = the controller, master = the key-pad side driving ps_* strobes.
interface doorlock_ctrl_param_if #(
    parameter int MAX_FAIL = 3
) ();
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic          ps_start;
    logic [3:0]    ps_num;
    logic          ps_num_valid;
    logic          ps_end;
    logic          ps_change;
    logic          door_open;
    logic [2:0]    state_out;
    logic          lockout;
    logic [FW-1:0] fail_cnt;
    logic [3:0]    digit_cnt;
    logic [2:0]    disp_code;
    logic          alarm;

    modport slave (
        input  ps_start, ps_num, ps_num_valid, ps_end, ps_change,
        output door_open, state_out, lockout, fail_cnt, digit_cnt, disp_code, alarm
    );

    modport master (
        output ps_start, ps_num, ps_num_valid, ps_end, ps_change,
        input  door_open, state_out, lockout, fail_cnt, digit_cnt, disp_code, alarm
    );
endinterface

// File: rtl/doorlock_ctrl_param.sv
// Parametrised password door lock: digit entry, programmable password,
// failed-attempt lockout and tick-based timeouts in one synchronous block.
// Optional feature macro: DOORLOCK_DURESS_EN (duress code opens and raises alarm).
module doorlock_ctrl_param #(
    parameter int                  PW_LEN      = 4,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW  = 16'h1234,
    parameter int                  CLK_DIV     = 50000,
    parameter int                  OPEN_TICKS  = 100,
    parameter int                  ERR_TICKS   = 20,
    parameter int                  LOCK_TICKS  = 600,
    parameter int                  ENTRY_TICKS = 200,
    parameter int                  MAX_FAIL    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    doorlock_ctrl_param_if.slave  bus
);
    localparam int PW_W  = PW_LEN * 4;
    localparam int FW    = $clog2(MAX_FAIL + 1);
    localparam int PS_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_A = (OPEN_TICKS > ERR_TICKS) ? OPEN_TICKS : ERR_TICKS;
    localparam int MAX_B = (LOCK_TICKS > ENTRY_TICKS) ? LOCK_TICKS : ENTRY_TICKS;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_OPEN   = 3'd2,
        S_ERROR  = 3'd3,
        S_LOCKED = 3'd4,
        S_PROG   = 3'd5
    } state_t;

    state_t          state, nxt;
    logic [PS_W-1:0] presc;
    logic [TW-1:0]   ticks;
    logic [PW_W-1:0] pw;
    logic [PW_W-1:0] entry_buf;
    logic [3:0]      digit_cnt;
    logic            ovf;
    logic [FW-1:0]   fail_cnt;

    logic            digit_ok, tick_last, tmr_en, timeout;
    logic            entry_full, pw_match;
    logic [FW-1:0]   fail_nxt;
    int              limit;
    logic            buf_clr, dig_acc, restart, fail_inc, fail_clr, pw_load, tmr_clr;

    assign digit_ok   = bus.ps_num_valid && (bus.ps_num <= 4'd9);
    assign tick_last  = (presc == PS_W'(CLK_DIV - 1));
    assign entry_full = (digit_cnt == 4'(PW_LEN)) && !ovf;
    assign pw_match   = entry_full && (entry_buf == pw);
    assign fail_nxt   = fail_cnt + FW'(1);

    // Timeout length for the current state; IDLE never times out
    always_comb begin
        limit  = 1;
        tmr_en = 1'b1;
        case (state)
            S_ENTRY, S_PROG: limit = ENTRY_TICKS;
            S_OPEN:          limit = OPEN_TICKS;
            S_ERROR:         limit = ERR_TICKS;
            S_LOCKED:        limit = LOCK_TICKS;
            default:         tmr_en = 1'b0;
        endcase
        timeout = tmr_en && tick_last && (ticks == TW'(limit - 1));
    end

`ifdef DOORLOCK_DURESS_EN
    logic [PW_W-1:0] dur_pw;
    logic            dur_match;
    logic            alarm_set;
    logic            alarm_q;

    // Duress code: stored password with last digit bumped modulo 10
    always_comb begin
        dur_pw      = pw;
        dur_pw[3:0] = (pw[3:0] >= 4'd9) ? 4'd0 : pw[3:0] + 4'd1;
        dur_match   = entry_full && (entry_buf == dur_pw);
    end
`endif

    // Next-state and datapath controls; inputs take priority over timeouts
    always_comb begin
        nxt      = state;
        buf_clr  = 1'b0;
        dig_acc  = 1'b0;
        restart  = 1'b0;
        fail_inc = 1'b0;
        fail_clr = 1'b0;
        pw_load  = 1'b0;
`ifdef DOORLOCK_DURESS_EN
        alarm_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (bus.ps_start) begin
                    nxt     = S_ENTRY;
                    buf_clr = 1'b1;
                end
            end
            S_ENTRY: begin
                if (bus.ps_start) begin
                    buf_clr = 1'b1;
                    restart = 1'b1;
                end else if (bus.ps_end) begin
                    if (pw_match) begin
                        nxt      = S_OPEN;
                        fail_clr = 1'b1;
                    end
`ifdef DOORLOCK_DURESS_EN
                    else if (dur_match) begin
                        nxt       = S_OPEN;
                        fail_clr  = 1'b1;
                        alarm_set = 1'b1;
                    end
`endif
                    else begin
                        fail_inc = 1'b1;
                        nxt      = (fail_nxt == FW'(MAX_FAIL)) ? S_LOCKED : S_ERROR;
                    end
                end else if (digit_ok) begin
                    dig_acc = 1'b1;
                end else if (timeout) begin
                    nxt = S_IDLE;
                end
            end
            S_OPEN: begin
                if (bus.ps_end) begin
                    nxt = S_IDLE;
                end else if (bus.ps_change) begin
                    nxt     = S_PROG;
                    buf_clr = 1'b1;
                end else if (timeout) begin
                    nxt = S_IDLE;
                end
            end
            S_PROG: begin
                if (bus.ps_end) begin
                    if (entry_full) begin
                        pw_load = 1'b1;
                        nxt     = S_IDLE;
                    end else begin
                        nxt = S_ERROR;
                    end
                end else if (digit_ok) begin
                    dig_acc = 1'b1;
                end else if (timeout) begin
                    nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                if (timeout) nxt = S_IDLE;
            end
            S_LOCKED: begin
                if (timeout) begin
                    nxt      = S_IDLE;
                    fail_clr = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
        tmr_clr = (nxt != state) || dig_acc || restart;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // Prescaler and tick counter, restarted on state change or accepted digit
    always_ff @(posedge clk) begin
        if (!rst || tmr_clr) begin
            presc <= '0;
            ticks <= '0;
        end else if (tick_last) begin
            presc <= '0;
            ticks <= ticks + TW'(1);
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    // Entry buffer: digits shift in at the LS end; extra digits only flag overflow
    always_ff @(posedge clk) begin
        if (!rst || buf_clr) begin
            entry_buf <= '0;
            digit_cnt <= '0;
            ovf       <= 1'b0;
        end else if (dig_acc) begin
            if (digit_cnt == 4'(PW_LEN)) begin
                ovf <= 1'b1;
            end else begin
                entry_buf <= (entry_buf << 4) | PW_W'(bus.ps_num);
                digit_cnt <= digit_cnt + 4'd1;
            end
        end
    end

    // Stored password, only reset restores the default
    always_ff @(posedge clk) begin
        if (!rst)         pw <= DEFAULT_PW;
        else if (pw_load) pw <= entry_buf;
    end

    // Consecutive failure counter
    always_ff @(posedge clk) begin
        if (!rst || fail_clr) fail_cnt <= '0;
        else if (fail_inc)    fail_cnt <= fail_nxt;
    end

`ifdef DOORLOCK_DURESS_EN
    // Sticky alarm, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst)           alarm_q <= 1'b0;
        else if (alarm_set) alarm_q <= 1'b1;
    end
    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.state_out = state;
    assign bus.disp_code = state;
    assign bus.door_open = (state == S_OPEN) || (state == S_PROG);
    assign bus.lockout   = (state == S_LOCKED);
    assign bus.fail_cnt  = fail_cnt;
    assign bus.digit_cnt = digit_cnt;
endmodule

// File: tb/tb_doorlock_ctrl_param.sv
// Scoreboard bench for doorlock_ctrl_param with short timer parameters.
module tb_doorlock_ctrl_param;
    localparam int CLK_DIV = 4, OPEN_TICKS = 3, ERR_TICKS = 2, LOCK_TICKS = 5;
    localparam int ENTRY_TICKS = 4, MAX_FAIL = 3;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] disp;
        logic       door;
        logic       lock;
        logic [1:0] fc;
        logic [3:0] dc;
        logic       al;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    doorlock_ctrl_param_if #(.MAX_FAIL(MAX_FAIL)) bus ();

    doorlock_ctrl_param #(
        .PW_LEN(4), .DEFAULT_PW(16'h1234), .CLK_DIV(CLK_DIV),
        .OPEN_TICKS(OPEN_TICKS), .ERR_TICKS(ERR_TICKS), .LOCK_TICKS(LOCK_TICKS),
        .ENTRY_TICKS(ENTRY_TICKS), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t sb_q[$];
    obs_t got, exp;
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic obs_t mk(input logic [2:0] st, input logic [1:0] fc,
                                input logic [3:0] dc, input logic al);
        obs_t o;
        o.st = st; o.disp = st;
        o.door = (st == 3'd2) || (st == 3'd5);
        o.lock = (st == 3'd4);
        o.fc = fc; o.dc = dc; o.al = al;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_out; o.disp = bus.disp_code; o.door = bus.door_open;
        o.lock = bus.lockout; o.fc = bus.fail_cnt; o.dc = bus.digit_cnt; o.al = bus.alarm;
        return o;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step();
    endtask

    task automatic do_start();
        bus.ps_start = 1'b1; step(); bus.ps_start = 1'b0;
    endtask

    task automatic do_end();
        bus.ps_end = 1'b1; step(); bus.ps_end = 1'b0;
    endtask

    task automatic do_change();
        bus.ps_change = 1'b1; step(); bus.ps_change = 1'b0;
    endtask

    task automatic do_digit(input logic [3:0] d);
        bus.ps_num = d; bus.ps_num_valid = 1'b1; step(); bus.ps_num_valid = 1'b0;
    endtask

    // start, then n digits of code, most significant digit first
    task automatic enter(input logic [31:0] code, input int n);
        do_start();
        for (int i = 0; i < n; i++) begin
            logic [31:0] c;
            c = code >> (4 * (n - 1 - i));
            do_digit(c[3:0]);
        end
    endtask

    task automatic test_reset();
        bus.ps_start = 0; bus.ps_num = 0; bus.ps_num_valid = 0; bus.ps_end = 0; bus.ps_change = 0;
        rst = 1'b0;
        sb_q.push_back(mk(0, 0, 0, 0)); idle_n(2);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL reset: got %p want %p", got, exp); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_open();
        enter(32'h1234, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL open_edge: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(2, 0, 4, 0)); idle_n(11);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL open_hold11: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 0, 4, 0)); step();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL open_relock12: got %p want %p", got, exp); else n_pass++;
    endtask

    task automatic test_lockout();
        for (int k = 1; k <= 2; k++) begin
            enter(32'h1235, 4);
            sb_q.push_back(mk(3, 2'(k), 4, 0)); do_end();
            exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_err%0d: got %p want %p", k, got, exp); else n_pass++;
            sb_q.push_back(mk(3, 2'(k), 4, 0)); idle_n(7);
            exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_errhold%0d: got %p want %p", k, got, exp); else n_pass++;
            sb_q.push_back(mk(0, 2'(k), 4, 0)); step();
            exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_erridle%0d: got %p want %p", k, got, exp); else n_pass++;
        end
        enter(32'h1235, 4);
        sb_q.push_back(mk(4, 3, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_enter: got %p want %p", got, exp); else n_pass++;
        do_start();
        sb_q.push_back(mk(4, 3, 4, 0)); idle_n(18);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_hold19: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 0, 4, 0)); step();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL lock_expire: got %p want %p", got, exp); else n_pass++;
    endtask

    task automatic test_length();
        enter(32'h123, 3);
        sb_q.push_back(mk(3, 1, 3, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL len_short: got %p want %p", got, exp); else n_pass++;
        idle_n(8);
        enter(32'h12, 2);
        sb_q.push_back(mk(1, 1, 2, 0)); do_digit(4'hA);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL len_nonbcd: got %p want %p", got, exp); else n_pass++;
        do_digit(4'd3); do_digit(4'd4);
        sb_q.push_back(mk(1, 1, 4, 0)); do_digit(4'd5);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL len_sat: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(3, 2, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL len_long: got %p want %p", got, exp); else n_pass++;
        idle_n(8);
        enter(32'h1234, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL len_clearopen: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL manual_relock: got %p want %p", got, exp); else n_pass++;
    endtask

    task automatic test_prog();
        enter(32'h1234, 4); do_end();
        sb_q.push_back(mk(5, 0, 0, 0)); do_change();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_enter: got %p want %p", got, exp); else n_pass++;
        do_digit(4'd9); do_digit(4'd8); do_digit(4'd7); do_digit(4'd6);
        sb_q.push_back(mk(0, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_store: got %p want %p", got, exp); else n_pass++;
        enter(32'h1234, 4);
        sb_q.push_back(mk(3, 1, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_oldpw: got %p want %p", got, exp); else n_pass++;
        idle_n(8);
        enter(32'h9876, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_newpw: got %p want %p", got, exp); else n_pass++;
        rst = 1'b0;
        sb_q.push_back(mk(0, 0, 0, 0)); step();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL midreset: got %p want %p", got, exp); else n_pass++;
        rst = 1'b1;
        enter(32'h1234, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL reset_pw: got %p want %p", got, exp); else n_pass++;
        do_change(); do_digit(4'd1); do_digit(4'd2);
        sb_q.push_back(mk(3, 0, 2, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_short: got %p want %p", got, exp); else n_pass++;
        idle_n(8);
        enter(32'h1234, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prog_pwkept: got %p want %p", got, exp); else n_pass++;
        do_end();
    endtask

    task automatic test_timeout_priority();
        enter(32'h1111, 4); do_end(); idle_n(8);
        enter(32'h1, 1);
        sb_q.push_back(mk(1, 1, 1, 0)); idle_n(15);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL tmo_hold: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 1, 1, 0)); step();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL tmo_idle: got %p want %p", got, exp); else n_pass++;
        enter(32'h1, 1);
        bus.ps_start = 1'b1; bus.ps_end = 1'b1;
        sb_q.push_back(mk(1, 1, 0, 0)); step();
        bus.ps_start = 1'b0; bus.ps_end = 1'b0;
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prio_restart: got %p want %p", got, exp); else n_pass++;
        enter(32'h1234, 4);
        sb_q.push_back(mk(2, 0, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL prio_open: got %p want %p", got, exp); else n_pass++;
        do_end();
    endtask

    task automatic test_duress();
        enter(32'h1235, 4);
`ifdef DOORLOCK_DURESS_EN
        sb_q.push_back(mk(2, 0, 4, 1)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL duress_open: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 0, 4, 1)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL duress_sticky: got %p want %p", got, exp); else n_pass++;
`else
        sb_q.push_back(mk(3, 1, 4, 0)); do_end();
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL duress_wrong: got %p want %p", got, exp); else n_pass++;
        sb_q.push_back(mk(0, 1, 4, 0)); idle_n(8);
        exp = sb_q.pop_front(); got = sample(); n_chk++; if (got !== exp) $display("FAIL duress_idle: got %p want %p", got, exp); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_open();
        test_lockout();
        test_length();
        test_prog();
        test_timeout_priority();
        test_duress();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
